// File: rtl/dmem_pkg.sv
// Shared types and helpers for the D-cache line-fill / write-back memory responder.
package dmem_pkg;

    typedef enum logic [2:0] {IDLE, WAIT, RBURST, WBURST, DONE} dmem_state_e;

    localparam int DEF_LINE_WORDS = 4;
    localparam int BEAT_W         = $clog2(DEF_LINE_WORDS);
    localparam int OFFS_W         = BEAT_W + 2;

    // Clears the byte-offset-within-line bits so every burst starts on a line boundary.
    function automatic logic [31:0] line_base(input logic [31:0] addr, input int offs_w = OFFS_W);
        logic [31:0] mask;
        mask = ~((32'd1 << offs_w) - 32'd1);
        return addr & mask;
    endfunction

endpackage

// File: rtl/dmem_burst_responder.sv
// Memory-side responder serving one line fill or line write-back at a time from a byte array.
// Optional line counters are enabled with `define DMEM_STATS_EN.
module dmem_burst_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH      = 65536,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int LATENCY    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic        rlast,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
`ifdef DMEM_STATS_EN
    output logic [31:0] stat_rd_lines,
    output logic [31:0] stat_wr_lines,
`endif
    output logic        wr_done
);

    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int CNT_W   = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int LOFFS_W = $clog2(LINE_WORDS) + 2;
    localparam int LAT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);
    localparam logic [LAT_W-1:0] LAT_INIT  = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

    logic [7:0]        mem [DEPTH];
    dmem_state_e       state_reg;
    logic [CNT_W-1:0]  beat_reg;
    logic [LAT_W-1:0]  lat_cnt_reg;
    logic [ADDR_W-1:0] base_reg;
    logic              we_reg;

    logic [ADDR_W-1:0] req_base;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [CNT_W-1:0]  beat_next;
    logic [31:0]       rd_word;
    logic              wr_hs;

    assign req_base  = ADDR_W'(line_base(req_addr, LOFFS_W));
    assign beat_next = beat_reg + CNT_W'(1);
    assign wr_addr   = base_reg + ADDR_W'({beat_reg, 2'b00});
    assign wr_hs     = (state_reg == WBURST) && wready && wvalid;

    // Read address targets the word that rdata must hold after the coming edge.
    always_comb begin
        rd_addr = base_reg;
        case (state_reg)
            IDLE:    rd_addr = req_base;
            RBURST:  rd_addr = base_reg + ADDR_W'({beat_next, 2'b00});
            default: rd_addr = base_reg;
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
        assign rd_word[8*gi +: 8] = mem[rd_addr + ADDR_W'(gi)];
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_hs) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[wr_addr + ADDR_W'(i)] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            req_ready   <= 1'b1;
            rvalid      <= 1'b0;
            rlast       <= 1'b0;
            wready      <= 1'b0;
            wr_done     <= 1'b0;
            rdata       <= '0;
            beat_reg    <= '0;
            lat_cnt_reg <= '0;
            base_reg    <= '0;
            we_reg      <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            case (state_reg)
                IDLE: if (req_valid) begin
                    base_reg  <= req_base;
                    we_reg    <= req_we;
                    beat_reg  <= '0;
                    req_ready <= 1'b0;
                    if (LATENCY > 0) begin
                        state_reg   <= WAIT;
                        lat_cnt_reg <= LAT_INIT;
                    end else if (req_we) begin
                        state_reg <= WBURST;
                        wready    <= 1'b1;
                    end else begin
                        state_reg <= RBURST;
                        rvalid    <= 1'b1;
                        rdata     <= rd_word;
                        rlast     <= (LINE_WORDS == 1);
                    end
                end
                WAIT: begin
                    if (lat_cnt_reg != '0) begin
                        lat_cnt_reg <= lat_cnt_reg - LAT_W'(1);
                    end else if (we_reg) begin
                        state_reg <= WBURST;
                        wready    <= 1'b1;
                    end else begin
                        state_reg <= RBURST;
                        rvalid    <= 1'b1;
                        rdata     <= rd_word;
                        rlast     <= (LINE_WORDS == 1);
                    end
                end
                RBURST: if (rready) begin
                    if (rlast) begin
                        state_reg <= IDLE;
                        rvalid    <= 1'b0;
                        rlast     <= 1'b0;
                        req_ready <= 1'b1;
                        beat_reg  <= '0;
                    end else begin
                        beat_reg <= beat_next;
                        rdata    <= rd_word;
                        rlast    <= (beat_next == LAST_BEAT);
                    end
                end
                WBURST: if (wvalid) begin
                    if (beat_reg == LAST_BEAT) begin
                        state_reg <= DONE;
                        wready    <= 1'b0;
                        wr_done   <= 1'b1;
                        beat_reg  <= '0;
                    end else begin
                        beat_reg <= beat_next;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef DMEM_STATS_EN
    // Saturating line counters; a fill counts on its final handshake, a write-back on its wr_done cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rd_lines <= '0;
            stat_wr_lines <= '0;
        end else begin
            if (state_reg == RBURST && rvalid && rready && rlast && stat_rd_lines != 32'hFFFF_FFFF)
                stat_rd_lines <= stat_rd_lines + 32'd1;
            if (state_reg == DONE && stat_wr_lines != 32'hFFFF_FFFF)
                stat_wr_lines <= stat_wr_lines + 32'd1;
        end
    end
`endif

endmodule
